// File: rtl/connect4_pkg.sv
// Shared constants for the 4x4 Connect-4 controller: datapath command codes,
// winner codes, board geometry and the ten winning lines.
package connect4_pkg;

  // Datapath command codes driven on the state output
  localparam logic [1:0] CMD_WAIT  = 2'b00;
  localparam logic [1:0] CMD_PLACE = 2'b01;
  localparam logic [1:0] CMD_CHECK = 2'b10;
  localparam logic [1:0] CMD_OVER  = 2'b11;

  // Winner codes
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int unsigned BOARD_CELLS = 16;
  localparam int unsigned NUM_LINES   = 10;

  // Each line packs four 4-bit cell indices (cell = row*4 + col, row 0 = bottom).
  // Index order: rows 0..3, columns 0..3, diagonal, anti-diagonal.
  localparam logic [NUM_LINES-1:0][3:0][3:0] WIN_LINES = {
    16'hC963,  // anti-diagonal 3,6,9,12
    16'hFA50,  // diagonal 0,5,10,15
    16'hFB73,  // column 3
    16'hEA62,  // column 2
    16'hD951,  // column 1
    16'hC840,  // column 0
    16'hFEDC,  // row 3
    16'hBA98,  // row 2
    16'h7654,  // row 1
    16'h3210   // row 0
  };

  function automatic logic [3:0] cell_idx(input int unsigned row, input int unsigned col);
    return 4'(row * 4 + col);
  endfunction

endpackage

// File: rtl/connect4_game_controller_if.sv
// Controller <-> datapath bus: move command out, board read-back in.
interface connect4_game_controller_if;
  logic [3:0]                           in_column;
  logic [1:0]                           state;
  logic [connect4_pkg::BOARD_CELLS-1:0] gameboard;
  logic [connect4_pkg::BOARD_CELLS-1:0] players_cells;
  logic                                 invalid_column;
  logic                                 next_player;

  // Controller side
  modport master (
    output in_column, state,
    input  gameboard, players_cells, invalid_column, next_player
  );

  // Datapath side
  modport slave (
    input  in_column, state,
    output gameboard, players_cells, invalid_column, next_player
  );
endinterface

// File: rtl/connect4_win_detect.sv
// Combinational line detector: flags a complete four-in-a-line for each player.
module connect4_win_detect
  import connect4_pkg::*;
(
  input  logic [BOARD_CELLS-1:0] gameboard,
  input  logic [BOARD_CELLS-1:0] players_cells,
  output logic                   p1_win,
  output logic                   p2_win
);

  logic occ, all_p1, all_p2;

  // Scan every winning line; a line counts only when all four cells are occupied
  always_comb begin
    p1_win = 1'b0;
    p2_win = 1'b0;
    occ    = 1'b0;
    all_p1 = 1'b0;
    all_p2 = 1'b0;
    for (int unsigned l = 0; l < NUM_LINES; l++) begin
      occ    = 1'b1;
      all_p1 = 1'b1;
      all_p2 = 1'b1;
      for (int unsigned k = 0; k < 4; k++) begin
        occ    = occ & gameboard[WIN_LINES[l][k]];
        all_p1 = all_p1 & ~players_cells[WIN_LINES[l][k]];
        all_p2 = all_p2 & players_cells[WIN_LINES[l][k]];
      end
      p1_win = p1_win | (occ & all_p1);
      p2_win = p2_win | (occ & all_p2);
    end
  end

endmodule

// File: rtl/connect4_game_controller.sv
// Connect-4 turn sequencer: qualifies button presses, sequences the datapath
// through PLACE/SETTLE/CHECK and publishes win/draw/invalid status.
// Optional turn timer: define CONNECT4_TURN_TIMER_EN.
module connect4_game_controller
  import connect4_pkg::*;
#(
  parameter int unsigned INVALID_HOLD = 8,
  parameter int unsigned TURN_TIMEOUT = 1000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 btn_column,
  connect4_game_controller_if.master dp,
  output logic                       current_player,
  output logic [1:0]                 winner,
  output logic                       game_over,
  output logic                       invalid_move,
  output logic [4:0]                 move_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PLACE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_OVER   = 3'd4;

  localparam int unsigned INV_W = $clog2(INVALID_HOLD + 1);

  logic [2:0]             fsm;
  logic [3:0]             btn_prev;
  logic [3:0]             col_q;
  logic [BOARD_CELLS-1:0] gb_q;
  logic [BOARD_CELLS-1:0] pc_q;
  logic                   inv_q;
  logic                   np_q;
  logic [INV_W-1:0]       inv_cnt;
  logic                   p1_win, p2_win;
  logic                   press_ok;
  logic                   timeout_hit;

  assign press_ok = (fsm == S_IDLE) && (btn_prev == '0) && $onehot(btn_column);

`ifdef CONNECT4_TURN_TIMER_EN
  localparam int unsigned TMR_W = $clog2(TURN_TIMEOUT);
  logic [TMR_W-1:0] turn_cnt;

  // Turn timer: idles at zero outside IDLE, so it restarts on every IDLE entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         turn_cnt <= '0;
    else if (fsm != S_IDLE || press_ok) turn_cnt <= '0;
    else if (!timeout_hit)              turn_cnt <= turn_cnt + 1'b1;
  end

  assign timeout_hit = (turn_cnt == TMR_W'(TURN_TIMEOUT - 1));
`else
  // No turn timer: IDLE waits indefinitely (TURN_TIMEOUT >= 2 keeps this low)
  assign timeout_hit = (TURN_TIMEOUT == 0);
`endif

  // Input staging: button history and datapath read-back, sampled every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_prev <= '0;
      gb_q     <= '0;
      pc_q     <= '0;
      inv_q    <= 1'b0;
      np_q     <= 1'b0;
    end else begin
      btn_prev <= btn_column;
      gb_q     <= dp.gameboard;
      pc_q     <= dp.players_cells;
      inv_q    <= dp.invalid_column;
      np_q     <= dp.next_player;
    end
  end

  connect4_win_detect u_win (
    .gameboard     (gb_q),
    .players_cells (pc_q),
    .p1_win        (p1_win),
    .p2_win        (p2_win)
  );

  // Turn sequencer and game status; CHECK judges the read-back latched at end of SETTLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm            <= S_IDLE;
      col_q          <= '0;
      current_player <= 1'b0;
      winner         <= WIN_NONE;
      move_count     <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (press_ok) begin
            col_q <= btn_column;
            fsm   <= S_PLACE;
          end else if (timeout_hit) begin
            winner <= np_q ? WIN_P1 : WIN_P2;
            fsm    <= S_OVER;
          end
        end
        S_PLACE:  fsm <= S_SETTLE;
        S_SETTLE: fsm <= S_CHECK;
        S_CHECK: begin
          if (inv_q) begin
            fsm <= S_IDLE;
          end else begin
            if (move_count != 5'd16) move_count <= move_count + 5'd1;
            current_player <= np_q;
            if (p1_win) begin
              winner <= WIN_P1;
              fsm    <= S_OVER;
            end else if (p2_win) begin
              winner <= WIN_P2;
              fsm    <= S_OVER;
            end else if (move_count == 5'd15) begin
              winner <= WIN_DRAW;
              fsm    <= S_OVER;
            end else begin
              fsm <= S_IDLE;
            end
          end
        end
        S_OVER:  fsm <= S_OVER;
        default: fsm <= S_IDLE;
      endcase
    end
  end

  // Invalid-move indicator hold counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        inv_cnt <= '0;
    else if (fsm == S_CHECK && inv_q)  inv_cnt <= INV_W'(INVALID_HOLD);
    else if (inv_cnt != '0)            inv_cnt <= inv_cnt - 1'b1;
  end

  // Datapath command decode
  always_comb begin
    case (fsm)
      S_PLACE:          dp.state = CMD_PLACE;
      S_SETTLE, S_CHECK: dp.state = CMD_CHECK;
      S_OVER:           dp.state = CMD_OVER;
      default:          dp.state = CMD_WAIT;
    endcase
  end

  assign dp.in_column  = (fsm == S_PLACE) ? col_q : '0;
  assign game_over     = (fsm == S_OVER);
  assign invalid_move  = (inv_cnt != '0);

endmodule

// File: tb/tb_connect4_game_controller.sv
// Scoreboard bench for connect4_game_controller with a behavioural datapath model.
`timescale 1ns/1ps
module tb_connect4_game_controller;
  import connect4_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn_column = '0;
  logic       current_player, game_over, invalid_move;
  logic [1:0] winner;
  logic [4:0] move_count;

  connect4_game_controller_if dp ();

  connect4_game_controller #(
    .INVALID_HOLD (8),
    .TURN_TIMEOUT (10)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_column     (btn_column),
    .dp             (dp.master),
    .current_player (current_player),
    .winner         (winner),
    .game_over      (game_over),
    .invalid_move   (invalid_move),
    .move_count     (move_count)
  );

  always #5 clk = ~clk;

  // Datapath model: drop a piece into the lowest free row on a PLACE command
  int m_col, m_row;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp.gameboard      <= '0;
      dp.players_cells  <= '0;
      dp.invalid_column <= 1'b0;
      dp.next_player    <= 1'b0;
    end else if (dp.state == CMD_PLACE) begin
      m_col = -1;
      m_row = -1;
      for (int i = 0; i < 4; i++) if (dp.in_column[i]) m_col = i;
      if (m_col >= 0)
        for (int r = 3; r >= 0; r--)
          if (!dp.gameboard[cell_idx(unsigned'(r), unsigned'(m_col))]) m_row = r;
      if (m_row < 0) begin
        dp.invalid_column <= 1'b1;
      end else begin
        dp.invalid_column <= 1'b0;
        dp.gameboard[cell_idx(unsigned'(m_row), unsigned'(m_col))]     <= 1'b1;
        dp.players_cells[cell_idx(unsigned'(m_row), unsigned'(m_col))] <= dp.next_player;
        dp.next_player <= ~dp.next_player;
      end
    end
  end

  typedef struct {
    logic [3:0] col;
    bit         chk;
    logic [4:0] mc;
    logic       cp;
    logic [1:0] win;
    logic       go;
    logic       inv;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int places = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every PLACE cycle pops one expectation; status is checked after CHECK
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && dp.state == CMD_PLACE) begin
        places++;
        chk("sb_pending_at_place", sb.size(), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("in_column", dp.in_column, e.col);
          if (e.chk) begin
            repeat (3) @(negedge clk);
            chk("move_count", move_count, e.mc);
            chk("current_player", current_player, e.cp);
            chk("winner", winner, e.win);
            chk("game_over", game_over, e.go);
            chk("invalid_move", invalid_move, e.inv);
          end
        end
      end
    end
  end

  task automatic press(input logic [3:0] col, input int hold, input bit move,
                       input logic [4:0] mc, input logic cp, input logic [1:0] win,
                       input logic inv);
    if (move) sb.push_back('{col, 1'b1, mc, cp, win, (win != WIN_NONE), inv});
    @(negedge clk);
    btn_column = col;
    repeat (hold) @(negedge clk);
    btn_column = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_state"}, dp.state, 0);
    chk({tag, "_in_column"}, dp.in_column, 0);
    chk({tag, "_current_player"}, current_player, 0);
    chk({tag, "_winner"}, winner, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_invalid_move"}, invalid_move, 0);
    chk({tag, "_move_count"}, move_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  logic [3:0] g2 [7]  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
  logic [3:0] g3 [16] = '{4'b0001, 4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001,
                          4'b0010, 4'b1000, 4'b1000, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0010};

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, cnt, p;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("after_reset");

    // Game 1: single press, dropped presses, column fill, invalid move
    press(4'b0001, 1, 1'b1, 5'd1, 1'b1, WIN_NONE, 1'b0);
    press(4'b0011, 1, 1'b0, 5'd0, 1'b0, WIN_NONE, 1'b0);
    chk("multibit_no_place", places, 1);
    chk("multibit_move_count", move_count, 1);
    press(4'b0100, 20, 1'b1, 5'd2, 1'b0, WIN_NONE, 1'b0);
    chk("held_one_place", places, 2);
    press(4'b0100, 1, 1'b1, 5'd3, 1'b1, WIN_NONE, 1'b0);
    press(4'b0100, 1, 1'b1, 5'd4, 1'b0, WIN_NONE, 1'b0);
    press(4'b0100, 1, 1'b1, 5'd5, 1'b1, WIN_NONE, 1'b0);

    sb.push_back('{4'b0100, 1'b1, 5'd5, 1'b1, WIN_NONE, 1'b0, 1'b1});
    @(negedge clk);
    btn_column = 4'b0100;
    @(negedge clk);
    btn_column = '0;
    n = 0;
    while (!invalid_move && n < 20) begin @(negedge clk); n++; end
    cnt = 0;
    while (invalid_move && cnt < 50) begin @(negedge clk); cnt++; end
    chk("invalid_hold_cycles", cnt, 8);
    chk("invalid_move_count", move_count, 5);

    // Asynchronous reset while a move is in PLACE
    sb.push_back('{4'b0010, 1'b0, 5'd0, 1'b0, WIN_NONE, 1'b0, 1'b0});
    @(negedge clk);
    btn_column = 4'b0010;
    @(negedge clk);
    btn_column = '0;
    chk("state_is_place", dp.state, CMD_PLACE);
    #2 reset = 1'b0;
    #1 check_idle_outputs("async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("after_abort");

    // Game 2: Player1 completes row 0
    for (int k = 0; k < 7; k++)
      press(g2[k], 1, 1'b1, 5'(k + 1), 1'((k + 1) % 2),
            (k == 6) ? WIN_P1 : WIN_NONE, 1'b0);
    chk("row_win_state", dp.state, CMD_OVER);
    p = places;
    press(4'b0001, 1, 1'b0, 5'd0, 1'b0, WIN_NONE, 1'b0);
    chk("over_ignores_press", places, p);
    chk("over_winner_held", winner, WIN_P1);

    // Game 3: sixteen moves, no line -> draw
    do_reset();
    check_idle_outputs("before_draw");
    for (int k = 0; k < 16; k++)
      press(g3[k], 1, 1'b1, 5'(k + 1), 1'((k + 1) % 2),
            (k == 15) ? WIN_DRAW : WIN_NONE, 1'b0);
    chk("draw_move_count", move_count, 16);
    chk("draw_state", dp.state, CMD_OVER);

`ifdef CONNECT4_TURN_TIMER_EN
    do_reset();
    press(4'b0001, 1, 1'b1, 5'd1, 1'b1, WIN_NONE, 1'b0);
    n = 0;
    while (!game_over && n < 40) begin @(negedge clk); n++; end
    chk("timeout_game_over", game_over, 1);
    chk("timeout_winner", winner, WIN_P1);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/connect4_game_controller.md
Name: connect4_game_controller

Overview:
- Top-level turn sequencer for the 4x4 Connect-4 datapath (column decoder + column selector).
- Accepts raw one-hot column buttons, qualifies them into single move requests and drives the datapath's in_column and state inputs.
- Reads back the gameboard/player-cell vectors to detect win, draw and invalid (full-column) moves.
- Publishes current player, winner and game-over status to the display logic.

Parameters:
- INVALID_HOLD, 8, cycles the invalid_move indicator stays high after a rejected move (>=1).
- TURN_TIMEOUT, 1000000, cycles allowed per turn when the turn timer is compiled in (>=2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- btn_column  in  4  raw column buttons, bit i = column i, one-hot when valid
- gameboard  in  16  datapath out_gameboard; cell index = row*4+col, row 0 = bottom; 1 = occupied
- players_cells  in  16  datapath out_players_cells; 0 = Player1, 1 = Player2 (valid only where occupied)
- invalid_column  in  1  datapath flag, valid in SETTLE: last commit hit a full column
- next_player  in  1  datapath turn flag: 0 = Player1 to move, 1 = Player2
- in_column  out  4  one-hot column to datapath; nonzero only in PLACE
- state  out  2  datapath command: 00 WAIT, 01 PLACE (commit move), 10 CHECK, 11 OVER
- current_player  out  1  registered copy of next_player, updated in CHECK
- winner  out  2  00 none, 01 Player1, 10 Player2, 11 draw
- game_over  out  1  high while FSM is in OVER
- invalid_move  out  1  high INVALID_HOLD cycles after a rejected move
- move_count  out  5  accepted moves, 0..16

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; column register, edge register and counters = 0.
- Reset is asynchronous, mid-operation included; it aborts any move in flight.
- Press qualification:
  - btn_prev is registered every cycle.
  - A press is accepted only when btn_prev == 0, btn_column is exactly one-hot, and FSM == IDLE.
  - Multi-bit, held, or non-IDLE presses are dropped, not queued.
- FSM (internal states → state output):
  - IDLE (00): on an accepted press at edge N, latch the column; go PLACE.
  - PLACE (01), edge N+1: in_column = latched column for exactly one cycle; datapath commits; go SETTLE.
  - SETTLE (10), edge N+2: datapath outputs now reflect the move; go CHECK.
  - CHECK (10), edge N+3, evaluated from registered inputs:
    - invalid_column = 1: move_count and player unchanged; load invalid counter with INVALID_HOLD; go IDLE.
    - A Player1 or Player2 line complete: winner = that player; go OVER.
    - Else if move_count+1 == 16: winner = 11; go OVER.
    - Otherwise go IDLE.
    - In every non-invalid case move_count increments and current_player = next_player.
  - OVER (11): all presses ignored; leaves only by reset.
- Win lines (10 total): 4 rows, 4 columns, diagonal cells {0,5,10,15}, anti-diagonal {3,6,9,12}.
  - A line belongs to player p when all 4 cells are occupied and all 4 player bits equal p.
  - If both players show a line (cannot arise from legal play), Player1 takes priority.
- invalid_move = (invalid counter != 0); the counter decrements to 0. A new invalid move reloads it.
- move_count saturates at 16.
- Decision latency: 4 edges from an accepted press to updated status; minimum 4 cycles per move.

Optional Feature:
- Macro: CONNECT4_TURN_TIMER_EN.
- Defined:
  - Turn counter clears on entry to IDLE and counts in IDLE.
  - When it reaches TURN_TIMEOUT-1 with no accepted press: the player to move forfeits, winner = opponent, go OVER.
  - A press accepted in the same cycle as the timeout wins; no forfeit.
- Undefined: no counter; IDLE waits indefinitely.

Decomposition:
- Package connect4_pkg: state command codes (00/01/10/11), winner codes, BOARD_CELLS = 16, the 10 win-line cell-index constants, and the cell index function row*4+col.
- Sub-module connect4_win_detect: combinational; gameboard + players_cells in, p1_win/p2_win out. FSM stays in the controller.

Test Plan:
- Reset release, no buttons → state = 00, all outputs 0; after reset, single btn_column = 0001 then 0000 → one PLACE cycle with in_column = 0001, move_count = 1, current_player = 1.
- btn_column = 0011, or held 0100 for 20 cycles → at most one move; multi-bit press produces no move.
- Model full column 2 (invalid_column = 1 in SETTLE) → move_count unchanged, invalid_move high exactly 8 cycles, player unchanged.
- Player1 fills row 0 (cells 0–3) with interleaved Player2 moves → winner = 01, game_over = 1, state = 11; later presses produce no PLACE.
- 16 moves with no line → winner = 11 at move 16, move_count = 16. Separately, assert reset during PLACE → all outputs 0 asynchronously, before the next clk edge.
- With CONNECT4_TURN_TIMER_EN and TURN_TIMEOUT = 10, Player2 to move and idle → winner = 01 after 10 cycles; press on cycle 10 → normal move.
